// File: rtl/hamming_secded_decoder.sv
// Streaming SECDED Hamming decoder: two-stage valid/ready pipeline that corrects single-bit
// errors, flags double/out-of-range errors and keeps saturating error counters.
module hamming_secded_decoder #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned CNT_W  = 16,
   // Fixed-point iteration of P = clog2(DATA_W+P+1); converges from below within two steps.
   localparam int unsigned P0    = $clog2(DATA_W + 2),
   localparam int unsigned P1    = $clog2(DATA_W + P0 + 1),
   localparam int unsigned P2    = $clog2(DATA_W + P1 + 1),
   localparam int unsigned P     = $clog2(DATA_W + P2 + 1),
   localparam int unsigned CW_W  = DATA_W + P + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_code,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [P-1:0]      out_syndrome,
   output logic              out_corr,
   output logic              out_uncorr,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic              s1_valid_q, s1_valid_d;
   logic [CW_W-1:0]   s1_code_q;
   logic              s2_valid_q, s2_valid_d;
   logic [DATA_W-1:0] s2_data_q;
   logic [P-1:0]      s2_syn_q;
   logic              s2_corr_q, s2_uncorr_q;
   logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
   logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

   logic              s2_load, s1_load, out_fire;
   logic [P-1:0]      syn;
   logic              par;
   logic              in_range;
   logic [CW_W-1:0]   fixed_code;
   logic [DATA_W-1:0] dec_data;
   logic              dec_corr, dec_uncorr;

   // Stage 2 can take new content when empty or when its word leaves this cycle.
   assign out_fire = s2_valid_q && out_ready;
   assign s2_load  = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_load;
   assign s1_load  = in_valid && in_ready;

   always_comb begin
      syn = '0;
      for (int unsigned k = 1; k < CW_W; k++) begin
         if (s1_code_q[k]) syn = syn ^ k[P-1:0];
      end
      par      = ^s1_code_q;
      in_range = (32'(syn) <= CW_W - 1);
   end

   always_comb begin
      dec_corr   = 1'b0;
      dec_uncorr = 1'b0;
      fixed_code = s1_code_q;
      if (syn == '0) begin
         dec_corr = par;
      end else if (!in_range || !par) begin
         dec_uncorr = 1'b1;
      end else begin
         dec_corr = 1'b1;
         for (int unsigned k = 1; k < CW_W; k++) begin
            if (k[P-1:0] == syn) fixed_code[k] = ~s1_code_q[k];
         end
      end
   end

   // Data bits occupy the non-power-of-two positions in ascending order.
   always_comb begin
      int unsigned j;
      j        = 0;
      dec_data = '0;
      for (int unsigned k = 1; k < CW_W; k++) begin
         if ((k & (k - 1)) != 0) begin
            dec_data[j] = fixed_code[k];
            j = j + 1;
         end
      end
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (s1_load) s1_valid_d = 1'b1;
      else if (s2_load) s1_valid_d = 1'b0;
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
   end

   // Clear takes priority over a same-cycle increment.
   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (cnt_clr) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end else if (out_fire) begin
         if (s2_corr_q && corr_cnt_q != CntMax) corr_cnt_d = corr_cnt_q + CNT_W'(1);
         if (s2_uncorr_q && uncorr_cnt_q != CntMax) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_code_q    <= '0;
         s2_valid_q   <= 1'b0;
         s2_data_q    <= '0;
         s2_syn_q     <= '0;
         s2_corr_q    <= 1'b0;
         s2_uncorr_q  <= 1'b0;
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s2_valid_q   <= s2_valid_d;
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
         if (s1_load) s1_code_q <= in_code;
         if (s2_load && s1_valid_q) begin
            s2_data_q   <= dec_data;
            s2_syn_q    <= syn;
            s2_corr_q   <= dec_corr;
            s2_uncorr_q <= dec_uncorr;
         end
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_data     = s2_data_q;
   assign out_syndrome = s2_syn_q;
   assign out_corr     = s2_corr_q;
   assign out_uncorr   = s2_uncorr_q;
   assign corr_cnt     = corr_cnt_q;
   assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Directed bench for hamming_secded_decoder: vector table for decode rules plus hand-written
// backpressure, reset, counter saturation and shortened-code sequences.
module tb_hamming_secded_decoder;

   logic       clk;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_code;
   logic [3:0] out_data;
   logic [2:0] out_syndrome;
   logic       out_corr, out_uncorr, cnt_clr;
   logic [1:0] corr_cnt, uncorr_cnt;

   logic        in_valid3, in_ready3, out_valid3;
   logic [6:0]  in_code3;
   logic [2:0]  out_data3, out_syndrome3;
   logic        out_corr3, out_uncorr3;
   logic [15:0] corr_cnt3, uncorr_cnt3;

   int n_chk  = 0;
   int n_pass = 0;

   hamming_secded_decoder #(.DATA_W(4), .CNT_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_syndrome(out_syndrome), .out_corr(out_corr), .out_uncorr(out_uncorr),
      .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   // DATA_W=3 gives a shortened code (positions 1..6), so syndrome 7 is out of range.
   hamming_secded_decoder #(.DATA_W(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_code(in_code3),
      .out_valid(out_valid3), .out_ready(1'b1), .out_data(out_data3),
      .out_syndrome(out_syndrome3), .out_corr(out_corr3), .out_uncorr(out_uncorr3),
      .cnt_clr(1'b0), .corr_cnt(corr_cnt3), .uncorr_cnt(uncorr_cnt3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required $finish before 200000");
      $fatal(1);
   end

   typedef struct {
      logic [7:0] code;
      logic [3:0] data;
      logic [2:0] syn;
      logic       corr;
      logic       uncorr;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int exp_corr, exp_uncorr;

   initial begin
      vecs[0] = '{8'hAA, 4'b1011, 3'd0, 1'b0, 1'b0};
      vecs[1] = '{8'h8A, 4'b1011, 3'd5, 1'b1, 1'b0};
      vecs[2] = '{8'hAB, 4'b1011, 3'd0, 1'b1, 1'b0};
      vecs[3] = '{8'hCA, 4'b1101, 3'd3, 1'b0, 1'b1};
      vecs[4] = '{8'h00, 4'b0000, 3'd0, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 4'b1111, 3'd0, 1'b0, 1'b0};
      vecs[6] = '{8'hFE, 4'b1111, 3'd0, 1'b1, 1'b0};
      vecs[7] = '{8'h02, 4'b0000, 3'd1, 1'b1, 1'b0};
      vecs[8] = '{8'h0C, 4'b0001, 3'd1, 1'b0, 1'b1};

      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_code   = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      in_valid3 = 1'b0;
      in_code3  = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_flags", {out_corr, out_uncorr, out_syndrome}, 0);
      chk("rst_counters", {corr_cnt, uncorr_cnt}, 0);
      step();
      step();
      rst_n = 1'b1;

      // Decode table, one word at a time, with a saturating counter model.
      exp_corr   = 0;
      exp_uncorr = 0;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_code  = vecs[i].code;
         step();
         in_valid = 1'b0;
         chk($sformatf("lat1_valid[%0d]", i), out_valid, 0);
         step();
         chk($sformatf("valid[%0d]", i), out_valid, 1);
         chk($sformatf("data[%0d]", i), out_data, vecs[i].data);
         chk($sformatf("syn[%0d]", i), out_syndrome, vecs[i].syn);
         chk($sformatf("corr[%0d]", i), out_corr, vecs[i].corr);
         chk($sformatf("uncorr[%0d]", i), out_uncorr, vecs[i].uncorr);
         if (vecs[i].corr && exp_corr < 3) exp_corr++;
         if (vecs[i].uncorr && exp_uncorr < 3) exp_uncorr++;
         step();
         chk($sformatf("corr_cnt[%0d]", i), corr_cnt, exp_corr);
         chk($sformatf("uncorr_cnt[%0d]", i), uncorr_cnt, exp_uncorr);
      end

      // Backpressure: three words offered while the sink stalls.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 8'hAA;
      chk("bp_ready_w0", in_ready, 1);
      step();
      in_code = 8'h8A;
      chk("bp_ready_w1", in_ready, 1);
      step();
      in_code = 8'hFF;
      chk("bp_ready_full", in_ready, 0);
      step();
      chk("bp_ready_stall", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", {out_data, out_syndrome, out_corr}, {4'b1011, 3'd0, 1'b0});
      step();
      chk("bp_hold_stable", {out_data, out_syndrome, out_corr}, {4'b1011, 3'd0, 1'b0});
      out_ready = 1'b1;
      #1;
      chk("bp_ready_release", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("bp_w1_valid", out_valid, 1);
      chk("bp_w1_data", {out_data, out_syndrome, out_corr}, {4'b1011, 3'd5, 1'b1});
      step();
      chk("bp_w2_valid", out_valid, 1);
      chk("bp_w2_data", {out_data, out_syndrome, out_corr}, {4'b1111, 3'd0, 1'b0});
      step();
      chk("bp_drained", out_valid, 0);

      // Reset with both stages full drops the words.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_code   = 8'hAA;
      step();
      in_code = 8'h8A;
      step();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_counters", {corr_cnt, uncorr_cnt}, 0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      step();
      chk("mid_rst_no_output", out_valid, 0);

      // Five corrected words back to back saturate a 2-bit counter at 3.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_code  = 8'h8A;
         chk($sformatf("tput_ready[%0d]", i), in_ready, 1);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      chk("sat_corr_cnt", corr_cnt, 3);
      chk("sat_drained", out_valid, 0);

      // Clear in the same cycle as a corrected-word delivery.
      in_valid = 1'b1;
      in_code  = 8'h8A;
      step();
      in_valid = 1'b0;
      step();
      chk("clr_valid", out_valid, 1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      chk("clr_wins", corr_cnt, 0);
      chk("clr_delivered", out_valid, 0);

      // Shortened code: syndrome 7 has no position, then a real single-bit fix.
      in_valid3 = 1'b1;
      in_code3  = 7'h16;
      step();
      in_code3 = 7'h29;
      step();
      in_valid3 = 1'b0;
      chk("short_valid", out_valid3, 1);
      chk("short_flags", {out_corr3, out_uncorr3}, 2'b01);
      chk("short_syn", out_syndrome3, 7);
      chk("short_data", out_data3, 0);
      step();
      chk("w3_flags", {out_corr3, out_uncorr3}, 2'b10);
      chk("w3_syn", out_syndrome3, 6);
      chk("w3_data", out_data3, 3'b111);
      step();
      chk("w3_counters", {corr_cnt3, uncorr_cnt3}, {16'd1, 16'd1});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
